// File: rtl/l1c_wbuf_pkg.sv
// l1c_wbuf_pkg: shared widths, AXI encodings, entry payload and drain FSM states
// for the L1 cache posted write buffer.
package l1c_wbuf_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned ID_W     = 10;
  localparam int unsigned LEN_W    = 8;
  localparam int unsigned SIZE_W   = 3;
  localparam int unsigned BURST_W  = 2;
  localparam int unsigned RESP_W   = 2;
  localparam int unsigned LINE_OFS = 4;
  localparam int unsigned LINE_W   = ADDR_W - LINE_OFS;

  localparam logic [BURST_W-1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [SIZE_W-1:0]  AXI_SIZE_4B    = 3'd2;
  localparam logic [RESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;

  // One queued write.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wbuf_entry_t;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_ADDR = 2'd1,
    D_RESP = 2'd2
  } drain_state_t;

  // Cache-line index of a byte address.
  function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:LINE_OFS];
  endfunction

endpackage

// File: rtl/l1c_wbuf_if.sv
// l1c_wbuf_if: single-beat AXI bundle (AW, W, B, AR, R channels).
// master modport drives addresses/data and the B/R ready; slave is the mirror.
interface l1c_wbuf_if;
  import l1c_wbuf_pkg::*;

  logic [ADDR_W-1:0]  awaddr;
  logic [ID_W-1:0]    awid;
  logic [LEN_W-1:0]   awlen;
  logic [SIZE_W-1:0]  awsize;
  logic [BURST_W-1:0] awburst;
  logic               awvalid;
  logic               awready;

  logic [DATA_W-1:0]  wdata;
  logic [STRB_W-1:0]  wstrb;
  logic [ID_W-1:0]    wid;
  logic               wlast;
  logic               wvalid;
  logic               wready;

  logic [RESP_W-1:0]  bresp;
  logic [ID_W-1:0]    bid;
  logic               bvalid;
  logic               bready;

  logic [ADDR_W-1:0]  araddr;
  logic [ID_W-1:0]    arid;
  logic [LEN_W-1:0]   arlen;
  logic [SIZE_W-1:0]  arsize;
  logic [BURST_W-1:0] arburst;
  logic               arvalid;
  logic               arready;

  logic [DATA_W-1:0]  rdata;
  logic [RESP_W-1:0]  rresp;
  logic [ID_W-1:0]    rid;
  logic               rlast;
  logic               rvalid;
  logic               rready;

  modport master (
    output awaddr, awid, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wid, wlast, wvalid, input wready,
    input  bresp, bid, bvalid, output bready,
    output araddr, arid, arlen, arsize, arburst, arvalid, input arready,
    input  rdata, rresp, rid, rlast, rvalid, output rready
  );

  modport slave (
    input  awaddr, awid, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wid, wlast, wvalid, output wready,
    output bresp, bid, bvalid, input bready,
    input  araddr, arid, arlen, arsize, arburst, arvalid, output arready,
    output rdata, rresp, rid, rlast, rvalid, input rready
  );

endinterface

// File: rtl/l1c_wbuf_fifo.sv
// l1c_wbuf_fifo: DEPTH-entry in-order write queue with per-entry valid bits
// and a line-address match across all valid entries.
// Ports: clk, rstn; push/push_entry write at wptr; pop advances rptr;
// head = entry at rptr; full/empty; line_addr in, line_hit out.
module l1c_wbuf_fifo
  import l1c_wbuf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  wbuf_entry_t       push_entry,
  input  logic              pop,
  output wbuf_entry_t       head,
  output logic              full,
  output logic              empty,
  input  logic [LINE_W-1:0] line_addr,
  output logic              line_hit
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wbuf_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] vld;

  assign head  = mem[rptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Storage carries no reset; vld gates every use of it.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_entry;
  end

  // Pointers wrap naturally because DEPTH is a power of two. A push is never
  // issued while full, so push and pop never target the same slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (push) begin
        wptr      <= wptr + PTR_W'(1);
        vld[wptr] <= 1'b1;
      end
      if (pop) begin
        rptr      <= rptr + PTR_W'(1);
        vld[rptr] <= 1'b0;
      end
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // Head entry keeps its valid bit until popped, so an in-flight drain still matches.
  always_comb begin
    line_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[PTR_W'(i)] && (line_of(mem[PTR_W'(i)].addr) == line_addr)) line_hit = 1'b1;
    end
  end

endmodule

// File: rtl/l1c_wbuf.sv
// l1c_wbuf: posted write buffer between the L1 cache AXI master and the system bus.
// Ports: clk, rstn; s (slave side, from the cache); m (master side, to the bus);
// wbuf_empty = nothing queued/held/in flight; wr_err = sticky downstream SLVERR/DECERR;
// err_clr clears wr_err (a coincident new error wins).
module l1c_wbuf
  import l1c_wbuf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  l1c_wbuf_if.slave  s,
  l1c_wbuf_if.master m,
  output logic       wbuf_empty,
  output logic       wr_err,
  input  logic       err_clr
);

  logic              aw_hold_vld, w_hold_vld;
  logic [ADDR_W-1:0] aw_hold_addr;
  logic [DATA_W-1:0] w_hold_data;
  logic [STRB_W-1:0] w_hold_strb;
  logic              bvalid_q;
  logic              aw_hs, w_hs, push, pop, full, empty;
  logic              fifo_hit, hazard, err_set;
  wbuf_entry_t       push_entry, head;
  drain_state_t      state_q, state_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic              m_awvalid_c, m_wvalid_c, m_bready_c;

  // Upstream capture: each channel has a single holding slot.
  assign s.awready = ~aw_hold_vld;
  assign s.wready  = ~w_hold_vld;
  assign aw_hs     = s.awvalid & ~aw_hold_vld;
  assign w_hs      = s.wvalid & ~w_hold_vld;

  // A push while the previous B is still unaccepted would lose a response.
  assign push = aw_hold_vld & w_hold_vld & ~full & ~(bvalid_q & ~s.bready);

  assign push_entry = '{addr: aw_hold_addr, data: w_hold_data, strb: w_hold_strb};

  // Holding registers; push and load are exclusive per channel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_hold_vld  <= 1'b0;
      w_hold_vld   <= 1'b0;
      aw_hold_addr <= '0;
      w_hold_data  <= '0;
      w_hold_strb  <= '0;
    end else begin
      if (push) begin
        aw_hold_vld <= 1'b0;
        w_hold_vld  <= 1'b0;
      end
      if (aw_hs) begin
        aw_hold_vld  <= 1'b1;
        aw_hold_addr <= s.awaddr;
      end
      if (w_hs) begin
        w_hold_vld  <= 1'b1;
        w_hold_data <= s.wdata;
        w_hold_strb <= s.wstrb;
      end
    end
  end

  // Early write response: acknowledged as soon as the entry is queued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         bvalid_q <= 1'b0;
    else if (push)     bvalid_q <= 1'b1;
    else if (s.bready) bvalid_q <= 1'b0;
  end

  assign s.bvalid = bvalid_q;
  assign s.bresp  = AXI_RESP_OKAY;
  assign s.bid    = '0;

  l1c_wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .line_addr  (line_of(s.araddr)),
    .line_hit   (fifo_hit)
  );

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= D_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Drain FSM next state: AW and W complete independently, then wait for B.
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    m_awvalid_c = 1'b0;
    m_wvalid_c  = 1'b0;
    m_bready_c  = 1'b0;
    pop         = 1'b0;
    err_set     = 1'b0;
    case (state_q)
      D_IDLE: begin
        if (!empty) state_d = D_ADDR;
      end
      D_ADDR: begin
        m_awvalid_c = ~aw_done_q;
        m_wvalid_c  = ~w_done_q;
        if (!aw_done_q && m.awready) aw_done_d = 1'b1;
        if (!w_done_q && m.wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          state_d   = D_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      D_RESP: begin
        m_bready_c = 1'b1;
        if (m.bvalid) begin
          pop     = 1'b1;
          err_set = m.bresp[1];
          state_d = D_IDLE;
        end
      end
      default: begin
        state_d = D_IDLE;
      end
    endcase
  end

  assign m.awvalid = m_awvalid_c;
  assign m.awaddr  = head.addr;
  assign m.awid    = '0;
  assign m.awlen   = '0;
  assign m.awsize  = AXI_SIZE_4B;
  assign m.awburst = AXI_BURST_INCR;
  assign m.wvalid  = m_wvalid_c;
  assign m.wdata   = head.data;
  assign m.wstrb   = head.strb;
  assign m.wid     = '0;
  assign m.wlast   = 1'b1;
  assign m.bready  = m_bready_c;

  // Sticky error; a new error takes priority over a clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        wr_err <= 1'b0;
    else if (err_set) wr_err <= 1'b1;
    else if (err_clr) wr_err <= 1'b0;
  end

  assign wbuf_empty = empty & ~aw_hold_vld & ~w_hold_vld & (state_q == D_IDLE);

  // Read-after-write hazard: stall AR while its line is queued or held.
  assign hazard = s.arvalid &
                  (fifo_hit | (aw_hold_vld & (line_of(aw_hold_addr) == line_of(s.araddr))));

  assign m.arvalid = s.arvalid & ~hazard;
  assign s.arready = m.arready & ~hazard;
  assign m.araddr  = s.araddr;
  assign m.arid    = s.arid;
  assign m.arlen   = s.arlen;
  assign m.arsize  = s.arsize;
  assign m.arburst = s.arburst;

  assign s.rdata  = m.rdata;
  assign s.rresp  = m.rresp;
  assign s.rid    = m.rid;
  assign s.rlast  = m.rlast;
  assign s.rvalid = m.rvalid;
  assign m.rready = s.rready;

  // Upstream burst/id fields are fixed by the supported subset; B id and OKAY/EXOKAY bit are ignored.
  logic unused_ok;
  assign unused_ok = ^{s.awid, s.awlen, s.awsize, s.awburst, s.wid, s.wlast, m.bid, m.bresp[0]};

endmodule

// File: tb/tb_l1c_wbuf.sv
// tb_l1c_wbuf: scenario tasks for the posted write buffer; downstream writes are
// checked against a queue of expected entries filled when each write is issued.
module tb_l1c_wbuf;
  import l1c_wbuf_pkg::*;

  logic clk = 1'b0;
  logic rstn, wbuf_empty, wr_err, err_clr;

  always #5 clk = ~clk;

  l1c_wbuf_if s_if ();
  l1c_wbuf_if m_if ();

  l1c_wbuf #(.DEPTH(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .s          (s_if),
    .m          (m_if),
    .wbuf_empty (wbuf_empty),
    .wr_err     (wr_err),
    .err_clr    (err_clr)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_dn  = 0;   // downstream writes completed (AW+W)
  int n_b   = 0;   // upstream B handshakes
  int n_awv = 0;   // cycles with m_awvalid high

  wbuf_entry_t exp_q [$];
  wbuf_entry_t e;
  logic [1:0]  bresp_cfg = 2'b00;

  logic        aw_seen, w_seen, drop_b;
  logic [31:0] mon_addr, mon_data;
  logic [3:0]  mon_strb;

  function automatic wbuf_entry_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    wbuf_entry_t r;
    r.addr = a;
    r.data = d;
    r.strb = st;
    return r;
  endfunction

  // Downstream slave model and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rstn) begin
      aw_seen = 1'b0;
      w_seen  = 1'b0;
      drop_b  = 1'b0;
      m_if.bvalid = 1'b0;
      m_if.bresp  = 2'b00;
      m_if.bid    = '0;
    end else begin
      if (m_if.awvalid) n_awv++;
      if (drop_b) begin
        m_if.bvalid = 1'b0;
        drop_b = 1'b0;
      end
      if (m_if.bvalid && m_if.bready) drop_b = 1'b1;
      if (m_if.awvalid && m_if.awready) begin
        aw_seen  = 1'b1;
        mon_addr = m_if.awaddr;
        n_cmp++;
        if ({m_if.awlen, m_if.awsize, m_if.awburst, m_if.awid} !== {8'd0, 3'd2, 2'b01, 10'd0}) begin
          n_err++;
          $display("FAIL aw_attr: got len=%0d size=%0d burst=%0d id=%0d, exp 0/2/1/0",
                   m_if.awlen, m_if.awsize, m_if.awburst, m_if.awid);
        end
      end
      if (m_if.wvalid && m_if.wready) begin
        w_seen   = 1'b1;
        mon_data = m_if.wdata;
        mon_strb = m_if.wstrb;
        n_cmp++;
        if (m_if.wlast !== 1'b1) begin
          n_err++;
          $display("FAIL w_last: got %b exp 1", m_if.wlast);
        end
      end
      if (aw_seen && w_seen) begin
        aw_seen = 1'b0;
        w_seen  = 1'b0;
        n_dn++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL dn_write: unexpected write addr=%h data=%h", mon_addr, mon_data);
        end else begin
          e = exp_q.pop_front();
          if ({mon_addr, mon_data, mon_strb} !== e) begin
            n_err++;
            $display("FAIL dn_write: got addr=%h data=%h strb=%h exp addr=%h data=%h strb=%h",
                     mon_addr, mon_data, mon_strb, e.addr, e.data, e.strb);
          end
        end
        m_if.bresp  = bresp_cfg;
        m_if.bvalid = 1'b1;
      end
      if (s_if.bvalid && s_if.bready) begin
        n_b++;
        n_cmp++;
        if ({s_if.bresp, s_if.bid} !== 12'd0) begin
          n_err++;
          $display("FAIL up_b: got bresp=%0d bid=%0d exp 0/0", s_if.bresp, s_if.bid);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one upstream write on both channels, waiting for acceptance.
  task automatic drive_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    bit aw_ok, w_ok, a_now, w_now;
    aw_ok = 1'b0;
    w_ok  = 1'b0;
    s_if.awaddr = a; s_if.wdata = d; s_if.wstrb = st;
    s_if.awvalid = 1'b1; s_if.wvalid = 1'b1;
    for (int k = 0; k < 60 && !(aw_ok && w_ok); k++) begin
      a_now = s_if.awvalid & s_if.awready;
      w_now = s_if.wvalid & s_if.wready;
      step();
      if (a_now) begin s_if.awvalid = 1'b0; aw_ok = 1'b1; end
      if (w_now) begin s_if.wvalid = 1'b0; w_ok = 1'b1; end
    end
    s_if.awvalid = 1'b0;
    s_if.wvalid  = 1'b0;
    n_cmp++;
    if (!(aw_ok && w_ok)) begin
      n_err++;
      $display("FAIL wr_accept: addr %h not accepted (aw=%b w=%b) exp both", a, aw_ok, w_ok);
    end
  endtask

  task automatic wait_empty(input string name);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (wbuf_empty) break;
    end
    n_cmp++;
    if (wbuf_empty !== 1'b1) begin
      n_err++;
      $display("FAIL %s_drain: wbuf_empty=%b exp 1 (timeout)", name, wbuf_empty);
    end
    step();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (wbuf_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b exp 1", wbuf_empty); end
    n_cmp++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b exp 0", wr_err); end
    n_cmp++; if ({s_if.bvalid, m_if.awvalid, m_if.wvalid, m_if.bready} !== 4'b0) begin
      n_err++; $display("FAIL rst_valids: got %b exp 0000", {s_if.bvalid, m_if.awvalid, m_if.wvalid, m_if.bready});
    end
    n_cmp++; if ({s_if.awready, s_if.wready} !== 2'b11) begin
      n_err++; $display("FAIL rst_ready: got %b exp 11", {s_if.awready, s_if.wready});
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    int dn0;
    dn0 = n_dn;
    exp_q.push_back(mk(32'h0000_1004, 32'hDEAD_BEEF, 4'hF));
    s_if.awaddr = 32'h0000_1004; s_if.wdata = 32'hDEAD_BEEF; s_if.wstrb = 4'hF;
    s_if.awvalid = 1'b1; s_if.wvalid = 1'b1;          // cycle T
    step();
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;          // cycle T+1
    @(negedge clk);
    n_cmp++; if (s_if.bvalid !== 1'b0) begin n_err++; $display("FAIL single_b_t1: got %b exp 0", s_if.bvalid); end
    n_cmp++; if (wbuf_empty !== 1'b0) begin n_err++; $display("FAIL single_busy: got %b exp 0", wbuf_empty); end
    step();                                           // cycle T+2
    @(negedge clk);
    n_cmp++; if (s_if.bvalid !== 1'b1) begin n_err++; $display("FAIL single_b_t2: got %b exp 1", s_if.bvalid); end
    step();
    wait_empty("single");
    n_cmp++; if (n_dn - dn0 !== 1) begin n_err++; $display("FAIL single_count: got %0d exp 1", n_dn - dn0); end
  endtask

  task automatic test_w_before_aw();
    int dn0;
    dn0 = n_dn;
    exp_q.push_back(mk(32'h0000_1100, 32'hCAFE_F00D, 4'h3));
    s_if.wdata = 32'hCAFE_F00D; s_if.wstrb = 4'h3; s_if.wvalid = 1'b1;   // T
    step();
    s_if.wvalid = 1'b0;                                                  // T+1
    step();                                                              // T+2
    @(negedge clk);
    n_cmp++; if ({s_if.wready, s_if.bvalid} !== 2'b00) begin
      n_err++; $display("FAIL wfirst_held: got wready,bvalid=%b exp 00", {s_if.wready, s_if.bvalid});
    end
    step();                                                              // T+3
    s_if.awaddr = 32'h0000_1100; s_if.awvalid = 1'b1;
    step();                                                              // T+4
    s_if.awvalid = 1'b0;
    @(negedge clk);
    n_cmp++; if (s_if.bvalid !== 1'b0) begin n_err++; $display("FAIL wfirst_b_t4: got %b exp 0", s_if.bvalid); end
    step();                                                              // T+5
    @(negedge clk);
    n_cmp++; if (s_if.bvalid !== 1'b1) begin n_err++; $display("FAIL wfirst_b_t5: got %b exp 1", s_if.bvalid); end
    step();
    wait_empty("wfirst");
    n_cmp++; if (n_dn - dn0 !== 1) begin n_err++; $display("FAIL wfirst_count: got %0d exp 1", n_dn - dn0); end
  endtask

  task automatic test_fill();
    int b0, dn0;
    b0 = n_b; dn0 = n_dn;
    m_if.awready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk(32'h0000_4000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 4'hF));
      drive_wr(32'h0000_4000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 4'hF);
    end
    repeat (4) step();
    @(negedge clk);
    n_cmp++; if (n_b - b0 !== 4) begin n_err++; $display("FAIL fill_acks: got %0d exp 4", n_b - b0); end
    n_cmp++; if ({s_if.bvalid, s_if.awready, s_if.wready} !== 3'b000) begin
      n_err++; $display("FAIL fill_stall: got bvalid,awready,wready=%b exp 000", {s_if.bvalid, s_if.awready, s_if.wready});
    end
    step();
    m_if.awready = 1'b1;
    wait_empty("fill");
    n_cmp++; if (n_b - b0 !== 5) begin n_err++; $display("FAIL fill_acks_end: got %0d exp 5", n_b - b0); end
    n_cmp++; if (n_dn - dn0 !== 5) begin n_err++; $display("FAIL fill_drained: got %0d exp 5", n_dn - dn0); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL fill_leftover: got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_raw_hazard();
    bit released;
    logic empty_at_release;
    released = 1'b0;
    empty_at_release = 1'b0;
    m_if.awready = 1'b0;
    exp_q.push_back(mk(32'h0000_2008, 32'h0000_0022, 4'hF));
    drive_wr(32'h0000_2008, 32'h0000_0022, 4'hF);
    repeat (3) step();
    s_if.araddr = 32'h0000_2000; s_if.arid = 10'h005; s_if.arlen = '0; s_if.arsize = 3'd2;
    s_if.arburst = 2'b01; s_if.arvalid = 1'b1;
    @(negedge clk);
    n_cmp++; if ({m_if.arvalid, s_if.arready} !== 2'b00) begin
      n_err++; $display("FAIL raw_stall: got arvalid,arready=%b exp 00", {m_if.arvalid, s_if.arready});
    end
    step();
    s_if.araddr = 32'h0000_3000;
    @(negedge clk);
    n_cmp++; if ({m_if.arvalid, s_if.arready, m_if.araddr, m_if.arid} !== {2'b11, 32'h0000_3000, 10'h005}) begin
      n_err++; $display("FAIL raw_pass: got v=%b r=%b addr=%h id=%h exp 1/1/00003000/005",
                        m_if.arvalid, s_if.arready, m_if.araddr, m_if.arid);
    end
    step();
    s_if.araddr = 32'h0000_2000;
    m_if.awready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (m_if.arvalid) begin
        released = 1'b1;
        empty_at_release = wbuf_empty;
        break;
      end
    end
    n_cmp++; if (!released || empty_at_release !== 1'b1) begin
      n_err++; $display("FAIL raw_release: released=%b empty=%b exp 1/1", released, empty_at_release);
    end
    step();
    s_if.arvalid = 1'b0;
    m_if.rdata = 32'h1234_5678; m_if.rresp = 2'b01; m_if.rvalid = 1'b1; m_if.rlast = 1'b1;
    @(negedge clk);
    n_cmp++; if ({s_if.rdata, s_if.rresp, s_if.rvalid, m_if.rready} !== {32'h1234_5678, 2'b01, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL r_pass: got data=%h resp=%0d v=%b rr=%b", s_if.rdata, s_if.rresp, s_if.rvalid, m_if.rready);
    end
    step();
    m_if.rvalid = 1'b0;
    wait_empty("raw");
  endtask

  task automatic test_error();
    bit hit;
    hit = 1'b0;
    bresp_cfg = 2'b01;
    exp_q.push_back(mk(32'h0000_5000, 32'h0000_0050, 4'hF));
    drive_wr(32'h0000_5000, 32'h0000_0050, 4'hF);
    wait_empty("exokay");
    n_cmp++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL err_exokay: got %b exp 0", wr_err); end
    bresp_cfg = 2'b10;
    exp_q.push_back(mk(32'h0000_5004, 32'h0000_0051, 4'hF));
    drive_wr(32'h0000_5004, 32'h0000_0051, 4'hF);
    wait_empty("slverr");
    repeat (3) step();
    @(negedge clk);
    n_cmp++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b exp 1", wr_err); end
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    n_cmp++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b exp 0", wr_err); end
    step();
    // err_clr held so that it coincides with the erroring B handshake.
    err_clr = 1'b1;
    exp_q.push_back(mk(32'h0000_5008, 32'h0000_0052, 4'hF));
    drive_wr(32'h0000_5008, 32'h0000_0052, 4'hF);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (m_if.bvalid && m_if.bready) begin
        hit = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    n_cmp++; if (!hit || wr_err !== 1'b1) begin
      n_err++; $display("FAIL err_priority: hit=%b wr_err=%b exp 1/1", hit, wr_err);
    end
    bresp_cfg = 2'b00;
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    wait_empty("err");
  endtask

  task automatic test_reset_during_drain();
    int awv0;
    m_if.awready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(32'h0000_6000 + 32'(i * 16), 32'h6666_0000 + 32'(i), 4'hF));
      drive_wr(32'h0000_6000 + 32'(i * 16), 32'h6666_0000 + 32'(i), 4'hF);
    end
    repeat (2) step();
    @(negedge clk);
    n_cmp++; if ({wbuf_empty, m_if.awvalid} !== 2'b01) begin
      n_err++; $display("FAIL rdrain_busy: got empty,awvalid=%b exp 01", {wbuf_empty, m_if.awvalid});
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    n_cmp++; if ({m_if.awvalid, m_if.wvalid, m_if.bready, s_if.bvalid} !== 4'b0) begin
      n_err++; $display("FAIL rdrain_valids: got %b exp 0000", {m_if.awvalid, m_if.wvalid, m_if.bready, s_if.bvalid});
    end
    n_cmp++; if (wbuf_empty !== 1'b1) begin n_err++; $display("FAIL rdrain_empty: got %b exp 1", wbuf_empty); end
    exp_q.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    m_if.awready = 1'b1;
    awv0 = n_awv;
    repeat (10) step();
    @(negedge clk);
    n_cmp++; if (n_awv - awv0 !== 0) begin n_err++; $display("FAIL rdrain_noaw: got %0d awvalid cycles exp 0", n_awv - awv0); end
    n_cmp++; if (wbuf_empty !== 1'b1) begin n_err++; $display("FAIL rdrain_idle: got %b exp 1", wbuf_empty); end
  endtask

  initial begin
    s_if.awaddr = '0; s_if.awid = '0; s_if.awlen = '0; s_if.awsize = 3'd2; s_if.awburst = 2'b01;
    s_if.awvalid = 1'b0;
    s_if.wdata = '0; s_if.wstrb = '0; s_if.wid = '0; s_if.wlast = 1'b1; s_if.wvalid = 1'b0;
    s_if.bready = 1'b1;
    s_if.araddr = '0; s_if.arid = '0; s_if.arlen = '0; s_if.arsize = '0; s_if.arburst = '0;
    s_if.arvalid = 1'b0; s_if.rready = 1'b1;
    m_if.awready = 1'b1; m_if.wready = 1'b1; m_if.arready = 1'b1;
    m_if.rdata = '0; m_if.rresp = '0; m_if.rid = '0; m_if.rlast = 1'b0; m_if.rvalid = 1'b0;
    err_clr = 1'b0;

    test_reset();
    test_single_write();
    test_w_before_aw();
    test_fill();
    test_raw_hazard();
    test_error();
    test_reset_during_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
